logic_unit_pipe: RTL and testbench

// - Pipelined, multi-lane, multi-op bitwise logic unit; successor to the single N-bit combinational OR core.
// - Applies one of 8 bitwise ops to LANES independent N-bit lane pairs.
// - Elastic valid/ready pipeline of STAGES register slots with a wrapping transaction counter.
// - Sits between TyTra kernel datapath stages that need backpressure-tolerant logic ops.

---
 rtl/logic_unit_pkg.sv | 28 ++
 rtl/logic_unit_stage.sv | 28 ++
 rtl/logic_unit_pipe.sv | 87 ++++++++
 tb/tb_logic_unit_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op codes and the per-bit logic function shared by the logic unit
package logic_unit_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    // All ops are bitwise, so one bit of a lane fully determines one bit of the result.
    function automatic logic lane_op(input logic a, input logic b, input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one elastic register slot (valid flag + data) with combinational ready pass-through
//   clk, rst           clock, synchronous active-high reset
//   up_valid/up_ready  upstream handshake, up_data word in
//   dn_valid/dn_ready  downstream handshake, dn_data word out (held while stalled or empty)
module logic_unit_stage #(
    parameter int DW = 75
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined multi-lane 8-op bitwise logic unit with elastic valid/ready slots
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; op, a, b sampled on transfer
//   out_valid/out_ready   output handshake; c and op_out held until accepted
//   cnt                   wrapping count of accepted input transfers
//   red                   per-lane OR-reduce of c, present only with LOGIC_UNIT_REDUCE_EN defined
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int N      = 18,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16,
    localparam int W     = N * LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     c,
    output logic [OP_W-1:0]  op_out,
    output logic [CNT_W-1:0] cnt
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic [LANES-1:0] red
`endif
);
`ifdef LOGIC_UNIT_REDUCE_EN
    localparam int DW = W + OP_W + LANES;
`else
    localparam int DW = W + OP_W;
`endif

    logic [W-1:0]    res;
    logic [STAGES:0] v;
    logic [STAGES:0] r;
    logic [DW-1:0]   d [STAGES+1];

    always_comb begin
        res = '0;
        for (int i = 0; i < W; i++) res[i] = lane_op(a[i], b[i], op);
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    logic [LANES-1:0] red_d;
    always_comb begin
        red_d = '0;
        for (int k = 0; k < LANES; k++) red_d[k] = |res[k*N +: N];
    end
    assign d[0] = {red_d, op, res};
    assign red  = d[STAGES][W+OP_W +: LANES];
`else
    assign d[0] = {op, res};
`endif

    assign v[0]      = in_valid;
    assign r[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_slot
        logic_unit_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (v[s]),
            .up_ready (r[s]),
            .up_data  (d[s]),
            .dn_valid (v[s+1]),
            .dn_ready (r[s+1]),
            .dn_data  (d[s+1])
        );
    end

    // Gating with rst keeps any handshake from completing in a reset cycle.
    assign in_ready  = r[0] && !rst;
    assign out_valid = v[STAGES] && !rst;
    assign c         = d[STAGES][W-1:0];
    assign op_out    = d[STAGES][W +: OP_W];

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (in_valid && in_ready) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [2:0]  op = 0;
    logic [71:0] a = 0;
    logic [71:0] b = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [71:0] c;
    logic [2:0]  op_out;
    logic [15:0] cnt;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic [3:0]  red;
`endif

    int n_assert = 0;
    int n_fail = 0;
    logic acc;
    logic ovld;
    logic [71:0] rx_c [$];
    logic [2:0]  rx_op [$];

    logic_unit_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .op_out    (op_out),
        .cnt       (cnt)
`ifdef LOGIC_UNIT_REDUCE_EN
        ,
        .red       (red)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] exp_lane(input logic [2:0] o, input logic [17:0] x, input logic [17:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return x & ~y;
            default: return x;
        endcase
    endfunction

    function automatic logic [71:0] exp_word(input logic [2:0] o, input logic [71:0] x, input logic [71:0] y);
        logic [71:0] w;
        for (int k = 0; k < 4; k++) w[k*18 +: 18] = exp_lane(o, x[k*18 +: 18], y[k*18 +: 18]);
        return w;
    endfunction

    // One clock of stimulus: drive, record handshakes away from the edge, advance to next negedge.
    task automatic cycle(input logic iv, input logic [2:0] o, input logic [71:0] aa, input logic [71:0] bb, input logic ordy);
        in_valid = iv;
        op = o;
        a = aa;
        b = bb;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        ovld = out_valid;
        if (out_valid && out_ready) begin
            rx_c.push_back(c);
            rx_op.push_back(op_out);
        end
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        rst = 0;
        rx_c.delete();
        rx_op.delete();
    endtask

    task automatic test_reset;
        rst = 1;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_low: got %b expected 0", out_valid); end
        rst = 0;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_assert++; if (c !== 72'h0) begin n_fail++; $display("FAIL reset_c: got %h expected 0", c); end
        n_assert++; if (op_out !== 3'd0) begin n_fail++; $display("FAIL reset_op_out: got %h expected 0", op_out); end
        n_assert++; if (cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
`ifdef LOGIC_UNIT_REDUCE_EN
        n_assert++; if (red !== 4'h0) begin n_fail++; $display("FAIL reset_red: got %b expected 0", red); end
`endif
    endtask

    task automatic test_or;
        cycle(1, 3'd1, {4{18'h00F0F}}, {4{18'h3F000}}, 1);
        n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL or_accept: got %b expected 1", acc); end
        cycle(0, 3'd0, 72'h0, 72'h0, 1);
        n_assert++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL or_early_valid: got %b expected 0", ovld); end
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL or_valid: got %b expected 1", out_valid); end
        n_assert++; if (c !== {4{18'h3FF0F}}) begin n_fail++; $display("FAIL or_c: got %h expected %h", c, {4{18'h3FF0F}}); end
        n_assert++; if (op_out !== 3'd1) begin n_fail++; $display("FAIL or_op_out: got %h expected 1", op_out); end
        n_assert++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL or_cnt: got %h expected 1", cnt); end
        cycle(0, 3'd0, 72'h0, 72'h0, 1);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL or_drained: got %b expected 0", out_valid); end
        n_assert++; if (c !== {4{18'h3FF0F}}) begin n_fail++; $display("FAIL or_c_hold_empty: got %h expected %h", c, {4{18'h3FF0F}}); end
    endtask

    task automatic test_sweep;
        logic [17:0] exp [8] = '{18'h0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h0, 18'h0, 18'h2AAAA, 18'h2AAAA};
        rx_c.delete();
        rx_op.delete();
        for (int i = 0; i < 12; i++) cycle(i < 8, 3'(i), {4{18'h2AAAA}}, {4{18'h15555}}, 1);
        n_assert++; if (rx_c.size() != 8) begin n_fail++; $display("FAIL sweep_count: got %0d expected 8", rx_c.size()); end
        for (int i = 0; i < 8 && i < rx_c.size(); i++) begin
            n_assert++; if (rx_c[i] !== {4{exp[i]}}) begin n_fail++; $display("FAIL sweep_c op%0d: got %h expected %h", i, rx_c[i], {4{exp[i]}}); end
            n_assert++; if (rx_op[i] !== 3'(i)) begin n_fail++; $display("FAIL sweep_op op%0d: got %h expected %0d", i, rx_op[i], i); end
        end
    endtask

    task automatic test_back_to_back;
        logic [71:0] ea [100];
        logic [71:0] eb [100];
        int bubbles = 0;
        int missed = 0;
        do_reset();
        for (int i = 0; i < 100; i++)
            for (int k = 0; k < 4; k++) begin
                ea[i][k*18 +: 18] = 18'(i * 977 + k * 12345 + 7);
                eb[i][k*18 +: 18] = 18'((i * 31) ^ 18'h15A5A) + 18'(k);
            end
        for (int i = 0; i < 102; i++) begin
            if (i < 100) cycle(1, 3'(i), ea[i], eb[i], 1);
            else cycle(0, 3'd0, 72'h0, 72'h0, 1);
            if (i < 100 && !acc) missed++;
            if (i >= 2 && !ovld) bubbles++;
        end
        n_assert++; if (missed != 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d refused cycles expected 0", missed); end
        n_assert++; if (bubbles != 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); end
        n_assert++; if (rx_c.size() != 100) begin n_fail++; $display("FAIL b2b_count: got %0d expected 100", rx_c.size()); end
        n_assert++; if (cnt !== 16'd100) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 100", cnt); end
        for (int i = 0; i < 100 && i < rx_c.size(); i++) begin
            n_assert++;
            if (rx_c[i] !== exp_word(3'(i), ea[i], eb[i]) || rx_op[i] !== 3'(i)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h/%0d expected %h/%0d", i, rx_c[i], rx_op[i], exp_word(3'(i), ea[i], eb[i]), i);
            end
        end
    endtask

    task automatic test_stall;
        logic [71:0] w [3] = '{{4{18'h01234}}, {4{18'h2F0F0}}, {4{18'h1C3C3}}};
        logic [71:0] m = {4{18'h0FF00}};
        do_reset();
        cycle(1, 3'd2, w[0], m, 0);
        n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_accept1: got %b expected 1", acc); end
        cycle(1, 3'd2, w[1], m, 0);
        n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_accept2: got %b expected 1", acc); end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'd2, w[2], m, 0);
            n_assert++; if (acc !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", acc); end
            n_assert++; if (out_valid !== 1'b1 || c !== exp_word(3'd2, w[0], m)) begin n_fail++; $display("FAIL stall_hold: got %b/%h expected 1/%h", out_valid, c, exp_word(3'd2, w[0], m)); end
        end
        cycle(1, 3'd2, w[2], m, 1);
        n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_drain_fill: got %b expected 1", acc); end
        for (int i = 0; i < 4; i++) cycle(0, 3'd0, 72'h0, 72'h0, 1);
        n_assert++; if (rx_c.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", rx_c.size()); end
        for (int i = 0; i < 3 && i < rx_c.size(); i++) begin
            n_assert++; if (rx_c[i] !== exp_word(3'd2, w[i], m)) begin n_fail++; $display("FAIL stall_order%0d: got %h expected %h", i, rx_c[i], exp_word(3'd2, w[i], m)); end
        end
        n_assert++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 3", cnt); end
    endtask

    task automatic test_wrap;
        do_reset();
        out_ready = 1;
        in_valid = 1;
        op = 3'd1;
        repeat (65535) @(negedge clk);
        n_assert++; if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h expected ffff", cnt); end
        @(negedge clk);
        in_valid = 0;
        n_assert++; if (cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", cnt); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        cycle(1, 3'd7, {4{18'h12345}}, 72'h0, 0);
        cycle(1, 3'd7, {4{18'h23456}}, 72'h0, 0);
        rst = 1;
        cycle(1, 3'd7, {4{18'h34567}}, 72'h0, 1);
        n_assert++; if (acc !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0", acc); end
        n_assert++; if (rx_c.size() != 0) begin n_fail++; $display("FAIL rstmid_out_xfer: got %0d expected 0", rx_c.size()); end
        n_assert++; if (out_valid !== 1'b0 || c !== 72'h0 || cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_state: got %b/%h/%h expected 0/0/0", out_valid, c, cnt); end
        rst = 0;
        for (int i = 0; i < 5; i++) cycle(0, 3'd0, 72'h0, 72'h0, 1);
        n_assert++; if (rx_c.size() != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d words expected 0", rx_c.size()); end
    endtask

`ifdef LOGIC_UNIT_REDUCE_EN
    task automatic test_reduce;
        do_reset();
        cycle(1, 3'd0, {4{18'h3FFFF}}, {18'h00001, 18'h00010, 18'h00000, 18'h00100}, 1);
        cycle(0, 3'd0, 72'h0, 72'h0, 1);
        n_assert++; if (out_valid !== 1'b1 || red !== 4'b1101) begin n_fail++; $display("FAIL reduce_red: got %b/%b expected 1/1101", out_valid, red); end
    endtask
`endif

    initial begin
        test_reset();
        test_or();
        test_sweep();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_midflight();
`ifdef LOGIC_UNIT_REDUCE_EN
        test_reduce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
